// File: rtl/pipe_serializer.sv
// pipe_serializer
//   Pulls one wide word per dequeue from an upstream one-entry FIFO and emits
//   it as BEATS narrow beats into a downstream enqueue port, least-significant
//   beat first. When the upstream word is ready on the final beat, it is fetched
//   in the same cycle, so back-to-back words leave no bubble.
//
// Ports
//   CLK            clock
//   nRST           synchronous active-low reset
//   in_first       upstream head word (BEAT_WIDTH*BEATS bits)
//   in_first__RDY  upstream head word valid
//   in_deq__RDY    upstream can dequeue
//   in_deq__ENA    dequeue strobe, one pulse per word
//   out_enq_v      beat payload
//   out_enq__ENA   enqueue strobe (never asserted without out_enq__RDY)
//   out_enq__RDY   downstream can accept a beat
//   busy           a word is held and not yet fully emitted
module pipe_serializer #(
   parameter int unsigned BEAT_WIDTH = 8,
   parameter int unsigned BEATS      = 4
) (
   input  logic                       CLK,
   input  logic                       nRST,
   input  logic [BEAT_WIDTH*BEATS-1:0] in_first,
   input  logic                       in_first__RDY,
   input  logic                       in_deq__RDY,
   output logic                       in_deq__ENA,
   output logic [BEAT_WIDTH-1:0]      out_enq_v,
   output logic                       out_enq__ENA,
   input  logic                       out_enq__RDY,
   output logic                       busy
);

   localparam int unsigned W  = BEAT_WIDTH * BEATS;
   localparam int unsigned CW = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t          st;
   logic [W-1:0]    shreg;
   logic [CW-1:0]   cnt;
   logic            fetch;
   logic            last;

   assign fetch        = in_first__RDY & in_deq__RDY;
   assign last         = (cnt == CW'(BEATS - 1));
   assign busy         = (st == SHIFT);
   assign out_enq__ENA = (st == SHIFT) & out_enq__RDY;
   assign out_enq_v    = shreg[BEAT_WIDTH-1:0];
   // Refill on the final accepted beat so consecutive words stream without a gap.
   assign in_deq__ENA  = fetch & ((st == IDLE) | (out_enq__ENA & last));

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         st    <= IDLE;
         shreg <= '0;
         cnt   <= '0;
      end else begin
         case (st)
            IDLE: begin
               if (in_deq__ENA) begin
                  shreg <= in_first;
                  cnt   <= '0;
                  st    <= SHIFT;
               end
            end
            SHIFT: begin
               if (out_enq__ENA) begin
                  if (!last) begin
                     shreg <= shreg >> BEAT_WIDTH;
                     cnt   <= cnt + CW'(1);
                  end else if (fetch) begin
                     shreg <= in_first;
                     cnt   <= '0;
                  end else begin
                     shreg <= '0;
                     cnt   <= '0;
                     st    <= IDLE;
                  end
               end
            end
            default: begin
               st    <= IDLE;
               shreg <= '0;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_serializer.sv
module tb_pipe_serializer;

   logic        CLK;
   logic        nRST;
   logic [31:0] in_first;
   logic        in_first__RDY;
   logic        in_deq__RDY;
   logic        in_deq__ENA;
   logic [7:0]  out_enq_v;
   logic        out_enq__ENA;
   logic        out_enq__RDY;
   logic        busy;

   int unsigned n_checks;
   int unsigned n_pass;

   pipe_serializer #(.BEAT_WIDTH(8), .BEATS(4)) dut (
      .CLK           (CLK),
      .nRST          (nRST),
      .in_first      (in_first),
      .in_first__RDY (in_first__RDY),
      .in_deq__RDY   (in_deq__RDY),
      .in_deq__ENA   (in_deq__ENA),
      .out_enq_v     (out_enq_v),
      .out_enq__ENA  (out_enq__ENA),
      .out_enq__RDY  (out_enq__RDY),
      .busy          (busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   function automatic logic [31:0] beat(input logic [31:0] word, input int unsigned k);
      return (word >> (8 * k)) & 32'hFF;
   endfunction

   task automatic set_up(input logic v);
      in_first__RDY = v;
      in_deq__RDY   = v;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_ena"},  32'(out_enq__ENA), 0);
      check({tag, "_v"},    32'(out_enq_v), 0);
      check({tag, "_deq"},  32'(in_deq__ENA), 0);
   endtask

   // One isolated word with downstream always ready.
   task automatic send_single(input string tag, input logic [31:0] word);
      in_first = word;
      set_up(1'b1);
      settle();
      check({tag, "_deq"}, 32'(in_deq__ENA), 1);
      step();
      set_up(1'b0);
      in_first = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         settle();
         check({tag, "_ena"}, 32'(out_enq__ENA), 1);
         check({tag, "_beat"}, 32'(out_enq_v), beat(word, k));
         check({tag, "_nodeq"}, 32'(in_deq__ENA), 0);
         step();
      end
      settle();
      check_idle({tag, "_end"});
   endtask

   // Random-phase model: a one-entry FIFO upstream and a queue of expected beats.
   logic [7:0]  exp_q[$];
   logic        fifo_full;
   int unsigned words_sent;
   int unsigned beats_seen;
   int unsigned cyc;
   logic        deq_seen;
   logic [31:0] w;
   logic [7:0]  e;

   initial begin
      n_checks = 0;
      n_pass   = 0;
      nRST = 1'b0;
      in_first = '0;
      set_up(1'b0);
      out_enq__RDY = 1'b1;
      step();
      step();
      nRST = 1'b1;
      settle();
      check_idle("rst");

      // Single word, then upstream starvation and a later word.
      send_single("sw", 32'h44332211);
      for (int unsigned i = 0; i < 5; i++) begin
         settle();
         check("starve_deq", 32'(in_deq__ENA), 0);
         check("starve_v", 32'(out_enq_v), 0);
         step();
      end
      send_single("late", 32'h88776655);

      // Back-to-back words.
      in_first = 32'hDDCCBBAA;
      set_up(1'b1);
      settle();
      check("b2b_deq0", 32'(in_deq__ENA), 1);
      step();
      in_first = 32'h04030201;
      for (int unsigned k = 0; k < 4; k++) begin
         settle();
         check("b2b_beatA", 32'(out_enq_v), beat(32'hDDCCBBAA, k));
         check("b2b_enaA", 32'(out_enq__ENA), 1);
         check("b2b_deqA", 32'(in_deq__ENA), (k == 3) ? 1 : 0);
         step();
      end
      set_up(1'b0);
      in_first = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         settle();
         check("b2b_beatB", 32'(out_enq_v), beat(32'h04030201, k));
         check("b2b_enaB", 32'(out_enq__ENA), 1);
         check("b2b_deqB", 32'(in_deq__ENA), 0);
         step();
      end
      settle();
      check_idle("b2b_end");

      // Backpressure on the 2nd and 3rd cycles of the word.
      in_first = 32'h44332211;
      set_up(1'b1);
      settle();
      check("bp_deq", 32'(in_deq__ENA), 1);
      step();
      set_up(1'b0);
      settle();
      check("bp_b0", 32'(out_enq_v), 32'h11);
      step();
      out_enq__RDY = 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
         settle();
         check("bp_stall_ena", 32'(out_enq__ENA), 0);
         check("bp_stall_v", 32'(out_enq_v), 32'h22);
         check("bp_stall_busy", 32'(busy), 1);
         step();
      end
      out_enq__RDY = 1'b1;
      for (int unsigned k = 1; k < 4; k++) begin
         settle();
         check("bp_ena", 32'(out_enq__ENA), 1);
         check("bp_beat", 32'(out_enq_v), beat(32'h44332211, k));
         step();
      end
      settle();
      check_idle("bp_end");

      // Reset after two beats discards the remainder.
      in_first = 32'h44332211;
      set_up(1'b1);
      settle();
      step();
      set_up(1'b0);
      for (int unsigned k = 0; k < 2; k++) begin
         settle();
         check("rm_beat", 32'(out_enq_v), beat(32'h44332211, k));
         step();
      end
      nRST = 1'b0;
      step();
      nRST = 1'b1;
      settle();
      check_idle("rm_rst");
      send_single("rm_next", 32'hA4A3A2A1);

      // Random traffic through a one-entry FIFO upstream.
      fifo_full  = 1'b0;
      words_sent = 0;
      beats_seen = 0;
      cyc        = 0;
      while ((words_sent < 1000 || exp_q.size() != 0 || fifo_full) && cyc < 20000) begin
         if (!fifo_full && words_sent < 1000 && ($urandom % 3) != 0) begin
            w = $urandom;
            fifo_full = 1'b1;
            in_first = w;
            words_sent++;
            for (int unsigned k = 0; k < 4; k++) exp_q.push_back(8'(beat(w, k)));
         end
         set_up(fifo_full);
         out_enq__RDY = (($urandom % 4) != 0);
         settle();
         if (out_enq__ENA) begin
            check("rnd_enq_rdy", 32'(out_enq__RDY), 1);
            if (exp_q.size() == 0) begin
               check("rnd_extra_beat", 32'(out_enq_v), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("rnd_beat", 32'(out_enq_v), 32'(e));
               beats_seen++;
            end
         end
         if (in_deq__ENA) check("rnd_deq_rdy", 32'(in_deq__RDY), 1);
         deq_seen = in_deq__ENA;
         step();
         if (deq_seen) fifo_full = 1'b0;
         cyc++;
      end
      check("rnd_timeout", 32'(cyc < 20000), 1);
      check("rnd_beat_count", beats_seen, 4000);
      check("rnd_q_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
